wb_tlc_cpl_enc: RTL and testbench

Transmit-side counterpart of the Wishbone TLP receive decoder. It takes one read-completion request from the Wishbone read engine and builds a 3DW-header CplD TLP on the 64-bit PCIe core transmit interface. Read data is pulled from a first-word-fall-through read-data FIFO and realigned by one DW behind the header. Unsupported lengths produce a data-less UR completion.

---
 rtl/wb_tlc_pkg.sv | 64 ++++++
 rtl/wb_tlc_dw_align.sv | 27 ++
 rtl/wb_tlc_cpl_enc.sv | 150 +++++++++++++++
 tb/tb_wb_tlc_cpl_enc.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_tlc_pkg.sv
// Shared constants, state encoding and header helpers for the Wishbone TLP completion encoder.
package wb_tlc_pkg;

  localparam logic [7:0] CPLD = 8'h4A;
  localparam logic [7:0] CPL  = 8'h0A;

  localparam logic [2:0] SC = 3'b000;
  localparam logic [2:0] UR = 3'b001;

  typedef enum logic [1:0] {IDLE, REQ, HDR, DATA} state_t;

  localparam int unsigned DW0_TYPE_LSB = 24;
  localparam int unsigned DW0_TC_LSB   = 20;
  localparam int unsigned DW0_ATTR_LSB = 12;
  localparam int unsigned DW0_LEN_LSB  = 0;
  localparam int unsigned DW1_CID_LSB  = 16;
  localparam int unsigned DW1_STAT_LSB = 13;
  localparam int unsigned DW1_BC_LSB   = 0;
  localparam int unsigned DW2_RID_LSB  = 16;
  localparam int unsigned DW2_TAG_LSB  = 8;
  localparam int unsigned DW2_LA_LSB   = 0;

  typedef struct packed {
    logic [9:0]  len;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [6:0]  lower_addr;
    logic [11:0] byte_cnt;
    logic [2:0]  tc;
    logic [1:0]  attr;
  } cpl_fields_t;

  function automatic logic [31:0] cpl_dw0(input logic [7:0] fmt_type, input logic [2:0] tc,
                                          input logic [1:0] attr, input logic [9:0] len);
    logic [31:0] dw;
    dw = '0;
    dw[DW0_TYPE_LSB +: 8] = fmt_type;
    dw[DW0_TC_LSB +: 3]   = tc;
    dw[DW0_ATTR_LSB +: 2] = attr;
    dw[DW0_LEN_LSB +: 10] = len;
    return dw;
  endfunction

  function automatic logic [31:0] cpl_dw1(input logic [15:0] cid, input logic [2:0] stat,
                                          input logic [11:0] bc);
    logic [31:0] dw;
    dw = '0;
    dw[DW1_CID_LSB +: 16] = cid;
    dw[DW1_STAT_LSB +: 3] = stat;
    dw[DW1_BC_LSB +: 12]  = bc;
    return dw;
  endfunction

  function automatic logic [31:0] cpl_dw2(input logic [15:0] rid, input logic [7:0] tag,
                                          input logic [6:0] la);
    logic [31:0] dw;
    dw = '0;
    dw[DW2_RID_LSB +: 16] = rid;
    dw[DW2_TAG_LSB +: 8]  = tag;
    dw[DW2_LA_LSB +: 7]   = la;
    return dw;
  endfunction

endpackage

// File: rtl/wb_tlc_dw_align.sv
// One-DW realignment: holds the lower DW of the previous FIFO word and pairs it with the current upper DW.
module wb_tlc_dw_align #(
  parameter int unsigned c_DATA_WIDTH = 64
) (
  input  logic                    clk_125,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clr,
  input  logic                    first,
  input  logic [c_DATA_WIDTH/2-1:0] hdr_dw,
  input  logic [c_DATA_WIDTH-1:0] cur,
  output logic [c_DATA_WIDTH-1:0] beat_c
);

  localparam int unsigned HALF = c_DATA_WIDTH / 2;

  logic [HALF-1:0] hold;

  always_ff @(posedge clk_125) begin
    if (rst || clr) hold <= '0;
    else if (load)  hold <= cur[HALF-1:0];
  end

  // First data beat carries the last header DW in front of the payload.
  assign beat_c = first ? {hdr_dw, cur[c_DATA_WIDTH-1:HALF]} : {hold, cur[c_DATA_WIDTH-1:HALF]};

endmodule

// File: rtl/wb_tlc_cpl_enc.sv
// Builds a 3DW CplD (or data-less UR Cpl) TLP on the 64-bit transmit interface from one read-completion request.
module wb_tlc_cpl_enc
  import wb_tlc_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 64,
  parameter int unsigned c_MAX_LEN_DW = 32
) (
  input  logic                    clk_125,
  input  logic                    rst,
  input  logic                    cpl_req,
  input  logic [9:0]              cpl_len,
  input  logic [15:0]             cpl_req_id,
  input  logic [7:0]              cpl_tag,
  input  logic [6:0]              cpl_lower_addr,
  input  logic [11:0]             cpl_byte_cnt,
  input  logic [2:0]              cpl_tc,
  input  logic [1:0]              cpl_attr,
  input  logic [15:0]             comp_id,
  output logic                    cpl_busy,
  output logic                    cpl_ack,
  output logic                    cpl_err,
  input  logic [c_DATA_WIDTH-1:0] rd_data,
  output logic                    rd_en,
  output logic                    tx_req,
  input  logic                    tx_rdy,
  output logic [c_DATA_WIDTH-1:0] tx_data,
  output logic                    tx_st,
  output logic                    tx_end,
  output logic                    tx_dwen
);

  localparam int unsigned HALF = c_DATA_WIDTH / 2;

  state_t      state;
  cpl_fields_t f;
  logic        ur_q;
  logic [5:0]  nbeats, npops, beat_cnt, pop_cnt;

  logic                    illegal_c, emit_c, last_c;
  logic [9:0]              beats_c, pops_c;
  logic [HALF-1:0]         dw2_c;
  logic [c_DATA_WIDTH-1:0] beat0_c, beat_c;

  assign illegal_c = (cpl_len == 10'd0) || (cpl_len > 10'(c_MAX_LEN_DW));
  assign beats_c   = (cpl_len + 10'd4) >> 1;
  assign pops_c    = (cpl_len + 10'd1) >> 1;

  // UR completions carry no data, fixed byte count and a zero lower address.
  assign beat0_c = {cpl_dw0(ur_q ? CPL : CPLD, f.tc, f.attr, ur_q ? 10'd0 : f.len),
                    cpl_dw1(comp_id, ur_q ? UR : SC, ur_q ? 12'd4 : f.byte_cnt)};
  assign dw2_c   = cpl_dw2(f.req_id, f.tag, ur_q ? 7'd0 : f.lower_addr);

  assign emit_c = ((state == HDR) || (state == DATA)) && !tx_end;
  assign last_c = (beat_cnt == nbeats - 6'd1);

  wb_tlc_dw_align #(.c_DATA_WIDTH(c_DATA_WIDTH)) u_align (
    .clk_125 (clk_125),
    .rst     (rst),
    .load    (emit_c),
    .clr     (state == IDLE),
    .first   (state == HDR),
    .hdr_dw  (dw2_c),
    .cur     (rd_data),
    .beat_c  (beat_c)
  );

  always_ff @(posedge clk_125) begin
    if (rst) begin
      state    <= IDLE;
      f        <= '0;
      ur_q     <= 1'b0;
      nbeats   <= '0;
      npops    <= '0;
      beat_cnt <= '0;
      pop_cnt  <= '0;
      cpl_busy <= 1'b0;
      cpl_ack  <= 1'b0;
      cpl_err  <= 1'b0;
      rd_en    <= 1'b0;
      tx_req   <= 1'b0;
      tx_data  <= '0;
      tx_st    <= 1'b0;
      tx_end   <= 1'b0;
      tx_dwen  <= 1'b0;
    end else begin
      cpl_ack <= 1'b0;
      cpl_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpl_req) begin
            f.len        <= cpl_len;
            f.req_id     <= cpl_req_id;
            f.tag        <= cpl_tag;
            f.lower_addr <= cpl_lower_addr;
            f.byte_cnt   <= cpl_byte_cnt;
            f.tc         <= cpl_tc;
            f.attr       <= cpl_attr;
            ur_q         <= illegal_c;
            nbeats       <= illegal_c ? 6'd2 : 6'(beats_c);
            npops        <= illegal_c ? 6'd0 : 6'(pops_c);
            cpl_err      <= illegal_c;
            cpl_busy     <= 1'b1;
            tx_req       <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (tx_rdy) begin
            tx_req   <= 1'b0;
            tx_st    <= 1'b1;
            tx_data  <= beat0_c;
            beat_cnt <= 6'd1;
            // The pop is issued one cycle ahead of the beat that consumes the word.
            rd_en    <= (npops != 6'd0);
            pop_cnt  <= (npops != 6'd0) ? 6'd1 : 6'd0;
            state    <= HDR;
          end
        end
        HDR, DATA: begin
          tx_st <= 1'b0;
          if (tx_end) begin
            tx_end   <= 1'b0;
            tx_dwen  <= 1'b0;
            tx_data  <= '0;
            rd_en    <= 1'b0;
            cpl_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            tx_data  <= ur_q ? {dw2_c, HALF'(0)} : beat_c;
            beat_cnt <= beat_cnt + 6'd1;
            if (last_c) begin
              tx_end  <= 1'b1;
              cpl_ack <= 1'b1;
              tx_dwen <= ur_q | ~f.len[0];
            end
            if (pop_cnt < npops) begin
              rd_en   <= 1'b1;
              pop_cnt <= pop_cnt + 6'd1;
            end else begin
              rd_en   <= 1'b0;
            end
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_tlc_cpl_enc.sv
// Scoreboard bench for the completion encoder: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_wb_tlc_cpl_enc;

  logic        clk_125 = 1'b0;
  logic        rst;
  logic        cpl_req;
  logic [9:0]  cpl_len;
  logic [15:0] cpl_req_id;
  logic [7:0]  cpl_tag;
  logic [6:0]  cpl_lower_addr;
  logic [11:0] cpl_byte_cnt;
  logic [2:0]  cpl_tc;
  logic [1:0]  cpl_attr;
  logic [15:0] comp_id;
  logic        cpl_busy, cpl_ack, cpl_err;
  logic [63:0] rd_data = 64'h0;
  logic        rd_en;
  logic        tx_req;
  logic        tx_rdy;
  logic [63:0] tx_data;
  logic        tx_st, tx_end, tx_dwen;

  always #4 clk_125 = ~clk_125;

  wb_tlc_cpl_enc dut (
    .clk_125(clk_125), .rst(rst), .cpl_req(cpl_req), .cpl_len(cpl_len),
    .cpl_req_id(cpl_req_id), .cpl_tag(cpl_tag), .cpl_lower_addr(cpl_lower_addr),
    .cpl_byte_cnt(cpl_byte_cnt), .cpl_tc(cpl_tc), .cpl_attr(cpl_attr), .comp_id(comp_id),
    .cpl_busy(cpl_busy), .cpl_ack(cpl_ack), .cpl_err(cpl_err), .rd_data(rd_data),
    .rd_en(rd_en), .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_data(tx_data), .tx_st(tx_st),
    .tx_end(tx_end), .tx_dwen(tx_dwen)
  );

  typedef struct {
    logic [63:0] data;
    logic [63:0] mask;
    logic        st;
    logic        en;
    logic        dwen;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] fifo_q[$];
  logic [63:0] wq[$];
  int n_vec = 0, n_bad = 0, n_pops = 0, n_err = 0, n_ack = 0;
  logic in_pkt = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [63:0] m, input logic st,
                           input logic en, input logic dw);
    beat_t b;
    b.data = d; b.mask = m; b.st = st; b.en = en; b.dwen = dw;
    exp_q.push_back(b);
  endtask

  // Reference model: flatten the TLP into a DW stream, then pack pairs into 64-bit beats.
  task automatic push_cpld(input logic [9:0] len, input logic [7:0] tag, input logic [6:0] la,
                           input logic [11:0] bc, input logic [2:0] tc, input logic [1:0] attr);
    logic [31:0] dws[$];
    logic [63:0] w;
    int nb;
    dws.push_back({8'h4A, 1'b0, tc, 4'b0, 2'b00, attr, 2'b00, len});
    dws.push_back({comp_id, 3'b000, 1'b0, bc});
    dws.push_back({cpl_req_id, tag, 1'b0, la});
    for (int i = 0; i < int'(len); i++) begin
      w = wq[i / 2];
      dws.push_back((i % 2 == 0) ? w[63:32] : w[31:0]);
    end
    if (dws.size() % 2 == 1) dws.push_back(32'h0);
    nb = dws.size() / 2;
    for (int k = 0; k < nb; k++)
      push_beat({dws[2*k], dws[2*k+1]},
                (k == nb - 1 && len[0] == 1'b0) ? 64'hFFFFFFFF_00000000 : 64'hFFFFFFFF_FFFFFFFF,
                k == 0, k == nb - 1, (k == nb - 1) && (len[0] == 1'b0));
  endtask

  task automatic send(input logic [9:0] len, input logic [7:0] tag, input logic [6:0] la,
                      input logic [11:0] bc, input logic [2:0] tc, input logic [1:0] attr);
    cpl_len = len; cpl_tag = tag; cpl_lower_addr = la; cpl_byte_cnt = bc;
    cpl_tc = tc; cpl_attr = attr; cpl_req = 1'b1;
    @(negedge clk_125);
    cpl_req = 1'b0;
    chk("req_lat", 64'(tx_req), 64'd1);
    chk("busy_set", 64'(cpl_busy), 64'd1);
  endtask

  task automatic grant(input int dly);
    for (int i = 0; i < 50 && !tx_req; i++) @(negedge clk_125);
    chk("req_seen", 64'(tx_req), 64'd1);
    repeat (dly) begin
      @(negedge clk_125);
      chk("req_hold", 64'(tx_req), 64'd1);
    end
    tx_rdy = 1'b1;
    @(negedge clk_125);
    tx_rdy = 1'b0;
    chk("st_lat", 64'(tx_st), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !cpl_busy) break;
      @(negedge clk_125);
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    chk("idle", 64'(cpl_busy), 64'd0);
  endtask

  // FWFT FIFO model: head presented on rd_data, popped on rd_en.
  always @(posedge clk_125) begin
    if (rd_en) begin
      n_pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    rd_data <= (fifo_q.size() > 0) ? fifo_q[0] : 64'h0;
  end

  always @(negedge clk_125) begin
    beat_t e;
    if (rst) in_pkt = 1'b0;
    else begin
      n_err += int'(cpl_err);
      n_ack += int'(cpl_ack);
      if (tx_st || in_pkt) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_beat: got %h want no beat", tx_data);
          in_pkt = 1'b0;
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", tx_data & e.mask, e.data & e.mask);
          chk("beat_flags", 64'({tx_st, tx_end, tx_dwen, cpl_ack}), 64'({e.st, e.en, e.dwen, e.en}));
          in_pkt = !tx_end;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int p0, e0, a0;
    rst = 1'b1; cpl_req = 1'b0; cpl_len = '0; cpl_tag = '0; cpl_lower_addr = '0;
    cpl_byte_cnt = '0; cpl_tc = '0; cpl_attr = '0; tx_rdy = 1'b0;
    cpl_req_id = 16'h0100; comp_id = 16'h0200;
    repeat (3) @(negedge clk_125);
    chk("rst_ctl", 64'({cpl_busy, cpl_ack, cpl_err, rd_en, tx_req, tx_st, tx_end, tx_dwen}), 64'd0);
    chk("rst_data", tx_data, 64'd0);
    rst = 1'b0;
    @(negedge clk_125);
    chk("idle_busy", 64'(cpl_busy), 64'd0);

    // len=1, grant three cycles late
    fifo_q.push_back(64'hAABBCCDD_11223344);
    p0 = n_pops; e0 = n_err; a0 = n_ack;
    push_beat(64'h4A000001_02000004, '1, 1'b1, 1'b0, 1'b0);
    push_beat(64'h01001200_AABBCCDD, '1, 1'b0, 1'b1, 1'b0);
    send(10'd1, 8'h12, 7'h00, 12'd4, 3'd0, 2'd0);
    grant(3);
    wait_idle();
    chk("len1_pops", 64'(n_pops - p0), 64'd1);
    chk("len1_ack", 64'(n_ack - a0), 64'd1);
    chk("len1_err", 64'(n_err - e0), 64'd0);

    // len=2, last beat upper DW only
    fifo_q.push_back(64'h11111111_22222222);
    p0 = n_pops;
    push_beat(64'h4A000002_02000008, '1, 1'b1, 1'b0, 1'b0);
    push_beat(64'h01003408_11111111, '1, 1'b0, 1'b0, 1'b0);
    push_beat(64'h22222222_00000000, 64'hFFFFFFFF_00000000, 1'b0, 1'b1, 1'b1);
    send(10'd2, 8'h34, 7'h08, 12'd8, 3'd0, 2'd0);
    grant(1);
    wait_idle();
    chk("len2_pops", 64'(n_pops - p0), 64'd1);

    // len=32, maximum payload, non-zero tc/attr
    wq.delete();
    for (int i = 0; i < 16; i++) begin
      wq.push_back({32'h1000_0000 + 32'(2 * i), 32'h1000_0000 + 32'(2 * i + 1)});
      fifo_q.push_back(wq[i]);
    end
    p0 = n_pops; a0 = n_ack;
    push_cpld(10'd32, 8'h5A, 7'h00, 12'd128, 3'd5, 2'd2);
    send(10'd32, 8'h5A, 7'h00, 12'd128, 3'd5, 2'd2);
    grant(0);
    wait_idle();
    chk("len32_pops", 64'(n_pops - p0), 64'd16);
    chk("len32_ack", 64'(n_ack - a0), 64'd1);

    // illegal lengths produce a UR completion without popping
    for (int t = 0; t < 2; t++) begin
      fifo_q.push_back(64'hDEADBEEF_DEADBEEF);
      p0 = n_pops; e0 = n_err;
      push_beat(64'h0A000000_02002004, '1, 1'b1, 1'b0, 1'b0);
      push_beat((t == 0) ? 64'h01007700_00000000 : 64'h01007800_00000000, '1, 1'b0, 1'b1, 1'b1);
      send((t == 0) ? 10'd0 : 10'd33, (t == 0) ? 8'h77 : 8'h78, 7'h55, 12'd40, 3'd0, 2'd0);
      chk("ur_err_pulse", 64'(cpl_err), 64'd1);
      grant(2);
      wait_idle();
      chk("ur_pops", 64'(n_pops - p0), 64'd0);
      chk("ur_err_cnt", 64'(n_err - e0), 64'd1);
      fifo_q.delete();
      @(negedge clk_125);
    end

    // second request while busy is ignored
    fifo_q.push_back(64'h55667788_99AABBCC);
    a0 = n_ack;
    push_beat(64'h4A000001_02000004, '1, 1'b1, 1'b0, 1'b0);
    push_beat(64'h01002103_55667788, '1, 1'b0, 1'b1, 1'b0);
    send(10'd1, 8'h21, 7'h03, 12'd4, 3'd0, 2'd0);
    cpl_len = 10'd4; cpl_tag = 8'h99; cpl_req = 1'b1;
    @(negedge clk_125);
    cpl_req = 1'b0;
    grant(1);
    wait_idle();
    repeat (4) begin
      @(negedge clk_125);
      chk("busy_ignored_req", 64'(tx_req), 64'd0);
    end
    chk("busy_ack", 64'(n_ack - a0), 64'd1);

    // reset in the middle of a data phase
    wq.delete();
    for (int i = 0; i < 16; i++) begin
      wq.push_back({32'h2000_0000 + 32'(i), 32'h3000_0000 + 32'(i)});
      fifo_q.push_back(wq[i]);
    end
    push_cpld(10'd32, 8'h66, 7'h00, 12'd128, 3'd0, 2'd0);
    send(10'd32, 8'h66, 7'h00, 12'd128, 3'd0, 2'd0);
    grant(0);
    repeat (3) @(negedge clk_125);
    rst = 1'b1;
    @(negedge clk_125);
    chk("midrst_ctl", 64'({cpl_busy, cpl_ack, cpl_err, rd_en, tx_req, tx_st, tx_end, tx_dwen}), 64'd0);
    chk("midrst_data", tx_data, 64'd0);
    exp_q.delete();
    fifo_q.delete();
    rst = 1'b0;
    @(negedge clk_125);
    fifo_q.push_back(64'hCAFEF00D_01234567);
    p0 = n_pops;
    push_beat(64'h4A000001_02000004, '1, 1'b1, 1'b0, 1'b0);
    push_beat(64'h01004400_CAFEF00D, '1, 1'b0, 1'b1, 1'b0);
    send(10'd1, 8'h44, 7'h00, 12'd4, 3'd0, 2'd0);
    grant(0);
    wait_idle();
    chk("post_rst_pops", 64'(n_pops - p0), 64'd1);

    // tx_rdy held high, request coincident with tx_end is dropped
    fifo_q.push_back(64'h0A0B0C0D_0E0F1011);
    a0 = n_ack;
    tx_rdy = 1'b1;
    push_beat(64'h4A000002_02000008, '1, 1'b1, 1'b0, 1'b0);
    push_beat(64'h01005510_0A0B0C0D, '1, 1'b0, 1'b0, 1'b0);
    push_beat(64'h0E0F1011_00000000, 64'hFFFFFFFF_00000000, 1'b0, 1'b1, 1'b1);
    send(10'd2, 8'h55, 7'h10, 12'd8, 3'd0, 2'd0);
    for (int i = 0; i < 20 && !tx_end; i++) @(negedge clk_125);
    chk("end_seen", 64'(tx_end), 64'd1);
    cpl_tag = 8'hEE; cpl_req = 1'b1;
    @(negedge clk_125);
    cpl_req = 1'b0;
    wait_idle();
    repeat (6) begin
      @(negedge clk_125);
      chk("rdy_held_no_req", 64'({tx_req, cpl_busy}), 64'd0);
    end
    chk("rdy_held_ack", 64'(n_ack - a0), 64'd1);
    tx_rdy = 1'b0;
    @(negedge clk_125);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
